// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one down-counting interval timer among NREQ requesters.
// The owner's interval is loaded on the grant edge; done pulses for one cycle on expiry.
module timer_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_VALUE = 10000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_count,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      q
);

  localparam int                IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0]  MAX_V = WIDTH'(MAX_VALUE);
  localparam logic [NREQ-1:0]   ONE   = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state, state_next;
  logic [NREQ-1:0]   grant_q, grant_next;
  logic [WIDTH-1:0]  cnt, cnt_next;
  logic [IDXW-1:0]   ptr, ptr_next;
  logic [IDXW-1:0]   owner, owner_next;

  logic              pick_valid;
  logic [IDXW-1:0]   pick_idx;
  logic [IDXW-1:0]   scan;
  logic [WIDTH-1:0]  pick_count;
  logic [WIDTH-1:0]  pick_clamped;

  // Scan upward from the slot after the last owner so the previous owner ranks last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = IDXW'((int'(ptr) + k) % NREQ);
      if (!pick_valid && req[scan]) begin
        pick_valid = 1'b1;
        pick_idx   = scan;
      end
    end
  end

  always_comb begin
    pick_count   = req_count[int'(pick_idx)*WIDTH +: WIDTH];
    pick_clamped = (pick_count > MAX_V) ? MAX_V : pick_count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      grant_q <= '0;
      cnt     <= '0;
      ptr     <= IDXW'(NREQ - 1);
      owner   <= '0;
    end else begin
      state   <= state_next;
      grant_q <= grant_next;
      cnt     <= cnt_next;
      ptr     <= ptr_next;
      owner   <= owner_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant_q;
    cnt_next   = cnt;
    ptr_next   = ptr;
    owner_next = owner;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = RUN;
          grant_next = ONE << pick_idx;
          cnt_next   = pick_clamped;
          owner_next = pick_idx;
        end
      end
      RUN: begin
        // Withdrawal wins over expiry, so a dropped request never sees done.
        if (!req[owner]) begin
          state_next = IDLE;
          grant_next = '0;
          cnt_next   = '0;
          ptr_next   = owner;
        end else if (cnt == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt - WIDTH'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
        grant_next = '0;
        cnt_next   = '0;
        ptr_next   = owner;
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        cnt_next   = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign done  = (state == DONE) ? grant_q : '0;
  assign busy  = (state != IDLE);
  assign q     = cnt;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: a vector table for single/zero-interval runs plus
// hand-written sequences for clamp, round-robin, withdrawal and async reset.
module tb_timer_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_count;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      q;

  timer_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_VALUE(10000)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_count (req_count),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .q         (q)
  );

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic [31:0] cnt;
    logic [3:0]  exp_grant;
    logic [3:0]  exp_done;
    logic        exp_busy;
    logic [31:0] exp_q;
  } vec_t;

  vec_t vecs[$];
  int   total_checks;
  int   pass_checks;
  int   rr_expected[5] = '{0, 1, 2, 3, 0};
  int   rr_idx;
  int   waited;
  logic found;
  logic saw_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual === expected) pass_checks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Drive inputs away from the edge, clock once, then sample 1 unit after the edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [NREQ*WIDTH-1:0] counts);
    @(negedge clk);
    req       = r;
    req_count = counts;
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input string name, input logic [3:0] r, input logic [31:0] c,
                        input logic [3:0] g, input logic [3:0] d, input logic b, input logic [31:0] qq);
    vec_t v;
    v.name = name; v.req = r; v.cnt = c;
    v.exp_grant = g; v.exp_done = d; v.exp_busy = b; v.exp_q = qq;
    vecs.push_back(v);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    total_checks = 0;
    pass_checks  = 0;
    rst          = 1'b0;
    req          = '0;
    req_count    = '0;

    // Reset state, observed before any clock edge
    #2;
    checkOutput("reset_grant", 32'(grant), 32'h0);
    checkOutput("reset_done",  32'(done),  32'h0);
    checkOutput("reset_busy",  32'(busy),  32'h0);
    checkOutput("reset_q",     q,          32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Single request L=5 from requester 0, then zero interval on requester 1
    addVec("idle_hold", 4'b0000, 32'd7, 4'b0000, 4'b0000, 1'b0, 32'd0);
    addVec("single_e0", 4'b0001, 32'd5, 4'b0001, 4'b0000, 1'b1, 32'd5);
    addVec("single_e1", 4'b0001, 32'd5, 4'b0001, 4'b0000, 1'b1, 32'd4);
    addVec("single_e2", 4'b0001, 32'd5, 4'b0001, 4'b0000, 1'b1, 32'd3);
    addVec("single_e3", 4'b0001, 32'd5, 4'b0001, 4'b0000, 1'b1, 32'd2);
    addVec("single_e4", 4'b0001, 32'd5, 4'b0001, 4'b0000, 1'b1, 32'd1);
    addVec("single_e5", 4'b0001, 32'd5, 4'b0001, 4'b0000, 1'b1, 32'd0);
    addVec("single_e6", 4'b0001, 32'd5, 4'b0001, 4'b0001, 1'b1, 32'd0);
    addVec("single_e7", 4'b0000, 32'd5, 4'b0000, 4'b0000, 1'b0, 32'd0);
    addVec("zero_e0",   4'b0010, 32'd0, 4'b0010, 4'b0000, 1'b1, 32'd0);
    addVec("zero_e1",   4'b0010, 32'd0, 4'b0010, 4'b0010, 1'b1, 32'd0);
    addVec("zero_e2",   4'b0000, 32'd0, 4'b0000, 4'b0000, 1'b0, 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, {NREQ{vecs[i].cnt}});
      checkOutput({vecs[i].name, "_grant"}, 32'(grant), 32'(vecs[i].exp_grant));
      checkOutput({vecs[i].name, "_done"},  32'(done),  32'(vecs[i].exp_done));
      checkOutput({vecs[i].name, "_busy"},  32'(busy),  32'(vecs[i].exp_busy));
      checkOutput({vecs[i].name, "_q"},     q,          vecs[i].exp_q);
    end

    // Clamp: 20000 on requester 2 loads 10000, expires after 10001 further edges
    applyStimulus(4'b0100, {32'd0, 32'd20000, 32'd0, 32'd0});
    checkOutput("clamp_grant", 32'(grant), 32'h4);
    checkOutput("clamp_q",     q,          32'd10000);
    saw_done = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if (done != '0) saw_done = 1'b1;
    end
    checkOutput("clamp_no_early_done", 32'(saw_done), 32'd0);
    checkOutput("clamp_q_zero",        q,             32'd0);
    @(posedge clk);
    #1;
    checkOutput("clamp_done", 32'(done), 32'h4);
    applyStimulus(4'b0000, '0);
    checkOutput("clamp_idle_busy", 32'(busy), 32'd0);

    // Withdrawal: requester 3 (L=100) drops at q=40, pending requester 0 follows
    applyStimulus(4'b1001, {32'd100, 32'd0, 32'd0, 32'd10});
    checkOutput("wd_grant", 32'(grant), 32'h8);
    checkOutput("wd_q0",    q,          32'd100);
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done != '0) saw_done = 1'b1;
    end
    checkOutput("wd_q40", q, 32'd40);
    applyStimulus(4'b0001, {32'd100, 32'd0, 32'd0, 32'd10});
    if (done != '0) saw_done = 1'b1;
    checkOutput("wd_grant_clear", 32'(grant),    32'h0);
    checkOutput("wd_busy_clear",  32'(busy),     32'd0);
    checkOutput("wd_q_clear",     q,             32'd0);
    checkOutput("wd_no_done",     32'(saw_done), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("wd_pending_grant", 32'(grant), 32'h1);
    checkOutput("wd_pending_q",     q,          32'd10);

    // Async reset mid-RUN at q=7, no clock edge needed
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ar_q7", q, 32'd7);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("ar_grant", 32'(grant), 32'h0);
    checkOutput("ar_q",     q,          32'd0);
    checkOutput("ar_busy",  32'(busy),  32'd0);
    checkOutput("ar_done",  32'(done),  32'h0);
    req = 4'b1001;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ar_restart_grant", 32'(grant), 32'h1);
    checkOutput("ar_restart_q",     q,          32'd10);

    // Round-robin: all four request L=2, each drops req for one edge after done
    doReset();
    req       = 4'b1111;
    req_count = {NREQ{32'd2}};
    for (int n = 0; n < 5; n++) begin
      found  = 1'b0;
      waited = 0;
      while (!found && waited < 20) begin
        @(posedge clk);
        #1;
        waited++;
        if (done != '0) found = 1'b1;
      end
      checkOutput("rr_done_seen", 32'(found), 32'd1);
      rr_idx = -1;
      for (int b = 0; b < NREQ; b++) if (done[b]) rr_idx = b;
      checkOutput("rr_order", 32'(rr_idx), 32'(rr_expected[n]));
      checkOutput("rr_done_matches_grant", 32'(done), 32'(grant));
      if (rr_idx >= 0) begin
        @(negedge clk);
        req[rr_idx] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rr_idle_after_done", 32'(busy), 32'd0);
        @(negedge clk);
        req[rr_idx] = 1'b1;
      end
    end
    req = '0;

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
